// File: rtl/vx_tl_pkg.sv
// Shared TileLink-UL constants for the Vortex core <-> tile memory glue.
package vx_tl_pkg;

    // TileLink-UL A-channel opcodes
    localparam logic [2:0] TL_OP_GET             = 3'd4;
    localparam logic [2:0] TL_OP_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_OP_PUT_PARTIAL     = 3'd1;

    // TileLink-UL D-channel opcodes
    localparam logic [2:0] TL_OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_OP_ACCESS_ACK_DATA = 3'd1;

    // log2 of the transfer size in bytes: every beat is one 32-bit word
    localparam logic [3:0] TL_SIZE_WORD = 4'd2;

    localparam int TL_ADDR_W   = 32;
    localparam int TL_DATA_W   = 32;
    localparam int TL_MASK_W   = TL_DATA_W / 8;
    localparam int CORE_ADDR_W = 30;  // core word address

    // A-channel opcode for a dcache lane request
    function automatic logic [2:0] tl_req_opcode(input logic rw, input logic [TL_MASK_W-1:0] byteen);
        if (!rw) begin
            return TL_OP_GET;
        end else if (byteen == {TL_MASK_W{1'b1}}) begin
            return TL_OP_PUT_FULL;
        end else begin
            return TL_OP_PUT_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/vx_tl_soft_reset.sv
// Soft-reset pulse generator: a rising edge on msip starts (or restarts)
// a pulse that is exactly RST_PULSE_LEN cycles long.
module vx_tl_soft_reset
    import vx_tl_pkg::*;
#(
    parameter int RST_PULSE_LEN = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic msip,
    output logic pulse
);

    localparam int CNT_W = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_PULSE_LEN - 1);

    logic             msip_q_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             pulse_reg;
    logic             pulse_next;
    logic             msip_rise;

    assign msip_rise = msip && !msip_q_reg;

    // Next-state: a rise reloads the counter, otherwise count down while the pulse holds
    always_comb begin
        count_next = count_reg;
        pulse_next = 1'b0;
        if (msip_rise) begin
            count_next = CNT_LOAD;
            pulse_next = 1'b1;
        end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
            pulse_next = 1'b1;
        end
    end

    // State registers, cleared immediately by the board reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            msip_q_reg <= 1'b0;
            count_reg  <= '0;
            pulse_reg  <= 1'b0;
        end else begin
            msip_q_reg <= msip;
            count_reg  <= count_next;
            pulse_reg  <= pulse_next;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/vx_tl_mem_adapter.sv
// Combinational glue between the Vortex icache/dcache ports and per-lane
// TileLink-UL A/D channels, plus the msip-driven core soft reset.
// Optional build macro: VX_TL_ACK_FILTER_EN -- when defined, AccessAck
// beats (store acks) do not raise dcache_rsp_valid.
module vx_tl_mem_adapter
    import vx_tl_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int TAG_WIDTH     = 10,
    parameter int RST_PULSE_LEN = 16
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  interrupts_msip,
    output logic                                  core_reset,

    // core fetch request / response
    input  logic                                  icache_req_valid,
    input  logic [CORE_ADDR_W-1:0]                icache_req_addr,
    input  logic [TAG_WIDTH-1:0]                  icache_req_tag,
    output logic                                  icache_req_ready,
    output logic                                  icache_rsp_valid,
    output logic [TL_DATA_W-1:0]                  icache_rsp_data,
    output logic [TAG_WIDTH-1:0]                  icache_rsp_tag,
    input  logic                                  icache_rsp_ready,

    // core data request / response
    input  logic [NUM_LANES-1:0]                  dcache_req_valid,
    input  logic [NUM_LANES-1:0]                  dcache_req_rw,
    input  logic [NUM_LANES-1:0][TL_MASK_W-1:0]   dcache_req_byteen,
    input  logic [NUM_LANES-1:0][CORE_ADDR_W-1:0] dcache_req_addr,
    input  logic [NUM_LANES-1:0][TL_DATA_W-1:0]   dcache_req_data,
    input  logic [NUM_LANES-1:0][TAG_WIDTH-1:0]   dcache_req_tag,
    output logic [NUM_LANES-1:0]                  dcache_req_ready,
    output logic                                  dcache_rsp_valid,
    output logic [NUM_LANES-1:0]                  dcache_rsp_tmask,
    output logic [NUM_LANES-1:0][TL_DATA_W-1:0]   dcache_rsp_data,
    output logic [TAG_WIDTH-1:0]                  dcache_rsp_tag,
    input  logic                                  dcache_rsp_ready,

    // instruction memory TileLink port
    output logic                                  imem_a_valid,
    output logic [2:0]                            imem_a_opcode,
    output logic [2:0]                            imem_a_param,
    output logic [3:0]                            imem_a_size,
    output logic [TAG_WIDTH-1:0]                  imem_a_source,
    output logic [TL_ADDR_W-1:0]                  imem_a_address,
    output logic [TL_MASK_W-1:0]                  imem_a_mask,
    output logic [TL_DATA_W-1:0]                  imem_a_data,
    output logic                                  imem_a_corrupt,
    input  logic                                  imem_a_ready,
    input  logic                                  imem_d_valid,
    input  logic [2:0]                            imem_d_opcode,
    input  logic [1:0]                            imem_d_param,
    input  logic [3:0]                            imem_d_size,
    input  logic [TAG_WIDTH-1:0]                  imem_d_source,
    input  logic [2:0]                            imem_d_sink,
    input  logic                                  imem_d_denied,
    input  logic [TL_DATA_W-1:0]                  imem_d_data,
    input  logic                                  imem_d_corrupt,
    output logic                                  imem_d_ready,

    // data memory TileLink ports, one per lane
    output logic [NUM_LANES-1:0]                  dmem_a_valid,
    output logic [NUM_LANES-1:0][2:0]             dmem_a_opcode,
    output logic [NUM_LANES-1:0][2:0]             dmem_a_param,
    output logic [NUM_LANES-1:0][3:0]             dmem_a_size,
    output logic [NUM_LANES-1:0][TAG_WIDTH-1:0]   dmem_a_source,
    output logic [NUM_LANES-1:0][TL_ADDR_W-1:0]   dmem_a_address,
    output logic [NUM_LANES-1:0][TL_MASK_W-1:0]   dmem_a_mask,
    output logic [NUM_LANES-1:0][TL_DATA_W-1:0]   dmem_a_data,
    output logic [NUM_LANES-1:0]                  dmem_a_corrupt,
    input  logic [NUM_LANES-1:0]                  dmem_a_ready,
    input  logic [NUM_LANES-1:0]                  dmem_d_valid,
    input  logic [NUM_LANES-1:0][2:0]             dmem_d_opcode,
    input  logic [NUM_LANES-1:0][1:0]             dmem_d_param,
    input  logic [NUM_LANES-1:0][3:0]             dmem_d_size,
    input  logic [NUM_LANES-1:0][TAG_WIDTH-1:0]   dmem_d_source,
    input  logic [NUM_LANES-1:0][2:0]             dmem_d_sink,
    input  logic [NUM_LANES-1:0]                  dmem_d_denied,
    input  logic [NUM_LANES-1:0][TL_DATA_W-1:0]   dmem_d_data,
    input  logic [NUM_LANES-1:0]                  dmem_d_corrupt,
    output logic [NUM_LANES-1:0]                  dmem_d_ready
);

    logic                 soft_pulse;
    logic [NUM_LANES-1:0] rsp_contrib;
    logic                 unused_inputs;

    // ---------------- soft reset ----------------
    vx_tl_soft_reset #(
        .RST_PULSE_LEN (RST_PULSE_LEN)
    ) u_soft_reset (
        .clock   (clock),
        .reset_n (reset_n),
        .msip    (interrupts_msip),
        .pulse   (soft_pulse)
    );

    assign core_reset = !reset_n || soft_pulse;

    // ---------------- fetch path ----------------
    assign imem_a_valid     = icache_req_valid;
    assign imem_a_opcode    = TL_OP_GET;
    assign imem_a_param     = 3'd0;
    assign imem_a_size      = TL_SIZE_WORD;
    assign imem_a_source    = icache_req_tag;
    assign imem_a_address   = {icache_req_addr, 2'b00};
    assign imem_a_mask      = {TL_MASK_W{1'b1}};
    assign imem_a_data      = '0;
    assign imem_a_corrupt   = 1'b0;
    assign icache_req_ready = imem_a_ready;

    // denied/corrupt are not reported to the core
    assign icache_rsp_valid = imem_d_valid;
    assign icache_rsp_data  = imem_d_data;
    assign icache_rsp_tag   = imem_d_source;
    assign imem_d_ready     = icache_rsp_ready;

    // ---------------- data path, per lane ----------------
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign dmem_a_valid[gi]     = dcache_req_valid[gi];
        assign dmem_a_opcode[gi]    = tl_req_opcode(dcache_req_rw[gi], dcache_req_byteen[gi]);
        assign dmem_a_param[gi]     = 3'd0;
        assign dmem_a_size[gi]      = TL_SIZE_WORD;
        assign dmem_a_source[gi]    = dcache_req_tag[gi];
        assign dmem_a_address[gi]   = {dcache_req_addr[gi], 2'b00};
        assign dmem_a_mask[gi]      = dcache_req_byteen[gi];
        assign dmem_a_data[gi]      = dcache_req_data[gi];
        assign dmem_a_corrupt[gi]   = 1'b0;
        assign dcache_req_ready[gi] = dmem_a_ready[gi];

        assign dcache_rsp_data[gi]  = dmem_d_data[gi];
        assign dmem_d_ready[gi]     = dcache_rsp_ready;

`ifdef VX_TL_ACK_FILTER_EN
        // store acks carry no data for the core, so they are consumed silently
        assign rsp_contrib[gi] = dmem_d_valid[gi] && (dmem_d_opcode[gi] != TL_OP_ACCESS_ACK);
`else
        assign rsp_contrib[gi] = dmem_d_valid[gi];
`endif
    end

    assign dcache_rsp_tmask = dmem_d_valid;
    assign dcache_rsp_valid = |rsp_contrib;

    // Response tag follows the highest-index valid lane; 0 when no lane is valid
    always_comb begin
        dcache_rsp_tag = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (dmem_d_valid[i]) begin
                dcache_rsp_tag = dmem_d_source[i];
            end
        end
    end

    // D-channel fields the core has no use for
    assign unused_inputs = ^{imem_d_opcode, imem_d_param, imem_d_size, imem_d_sink,
                             imem_d_denied, imem_d_corrupt,
                             dmem_d_opcode, dmem_d_param, dmem_d_size, dmem_d_sink,
                             dmem_d_denied, dmem_d_corrupt};

endmodule

// File: tb/tb_vx_tl_mem_adapter.sv
// Directed self-checking bench for vx_tl_mem_adapter.
// Expectations follow VX_TL_ACK_FILTER_EN the same way the design build does.
module tb_vx_tl_mem_adapter;

    localparam int NL = 4;
    localparam int TW = 10;

    logic clock = 1'b0;
    logic reset_n;
    logic interrupts_msip;
    logic core_reset;

    logic icache_req_valid;
    logic [29:0] icache_req_addr;
    logic [TW-1:0] icache_req_tag;
    logic icache_req_ready;
    logic icache_rsp_valid;
    logic [31:0] icache_rsp_data;
    logic [TW-1:0] icache_rsp_tag;
    logic icache_rsp_ready;

    logic [NL-1:0] dcache_req_valid, dcache_req_rw, dcache_req_ready;
    logic [NL-1:0][3:0] dcache_req_byteen;
    logic [NL-1:0][29:0] dcache_req_addr;
    logic [NL-1:0][31:0] dcache_req_data;
    logic [NL-1:0][TW-1:0] dcache_req_tag;
    logic dcache_rsp_valid;
    logic [NL-1:0] dcache_rsp_tmask;
    logic [NL-1:0][31:0] dcache_rsp_data;
    logic [TW-1:0] dcache_rsp_tag;
    logic dcache_rsp_ready;

    logic imem_a_valid, imem_a_corrupt, imem_a_ready;
    logic [2:0] imem_a_opcode, imem_a_param;
    logic [3:0] imem_a_size, imem_a_mask;
    logic [TW-1:0] imem_a_source;
    logic [31:0] imem_a_address, imem_a_data;
    logic imem_d_valid, imem_d_denied, imem_d_corrupt, imem_d_ready;
    logic [2:0] imem_d_opcode, imem_d_sink;
    logic [1:0] imem_d_param;
    logic [3:0] imem_d_size;
    logic [TW-1:0] imem_d_source;
    logic [31:0] imem_d_data;

    logic [NL-1:0] dmem_a_valid, dmem_a_corrupt, dmem_a_ready;
    logic [NL-1:0][2:0] dmem_a_opcode, dmem_a_param;
    logic [NL-1:0][3:0] dmem_a_size, dmem_a_mask;
    logic [NL-1:0][TW-1:0] dmem_a_source;
    logic [NL-1:0][31:0] dmem_a_address, dmem_a_data;
    logic [NL-1:0] dmem_d_valid, dmem_d_denied, dmem_d_corrupt, dmem_d_ready;
    logic [NL-1:0][2:0] dmem_d_opcode, dmem_d_sink;
    logic [NL-1:0][1:0] dmem_d_param;
    logic [NL-1:0][3:0] dmem_d_size;
    logic [NL-1:0][TW-1:0] dmem_d_source;
    logic [NL-1:0][31:0] dmem_d_data;

    int checks = 0;
    int errors = 0;
    int high_cnt;

    vx_tl_mem_adapter #(.NUM_LANES(NL), .TAG_WIDTH(TW), .RST_PULSE_LEN(16)) dut (
        .clock(clock), .reset_n(reset_n), .interrupts_msip(interrupts_msip), .core_reset(core_reset),
        .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
        .icache_req_tag(icache_req_tag), .icache_req_ready(icache_req_ready),
        .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data),
        .icache_rsp_tag(icache_rsp_tag), .icache_rsp_ready(icache_rsp_ready),
        .dcache_req_valid(dcache_req_valid), .dcache_req_rw(dcache_req_rw),
        .dcache_req_byteen(dcache_req_byteen), .dcache_req_addr(dcache_req_addr),
        .dcache_req_data(dcache_req_data), .dcache_req_tag(dcache_req_tag),
        .dcache_req_ready(dcache_req_ready), .dcache_rsp_valid(dcache_rsp_valid),
        .dcache_rsp_tmask(dcache_rsp_tmask), .dcache_rsp_data(dcache_rsp_data),
        .dcache_rsp_tag(dcache_rsp_tag), .dcache_rsp_ready(dcache_rsp_ready),
        .imem_a_valid(imem_a_valid), .imem_a_opcode(imem_a_opcode), .imem_a_param(imem_a_param),
        .imem_a_size(imem_a_size), .imem_a_source(imem_a_source), .imem_a_address(imem_a_address),
        .imem_a_mask(imem_a_mask), .imem_a_data(imem_a_data), .imem_a_corrupt(imem_a_corrupt),
        .imem_a_ready(imem_a_ready), .imem_d_valid(imem_d_valid), .imem_d_opcode(imem_d_opcode),
        .imem_d_param(imem_d_param), .imem_d_size(imem_d_size), .imem_d_source(imem_d_source),
        .imem_d_sink(imem_d_sink), .imem_d_denied(imem_d_denied), .imem_d_data(imem_d_data),
        .imem_d_corrupt(imem_d_corrupt), .imem_d_ready(imem_d_ready),
        .dmem_a_valid(dmem_a_valid), .dmem_a_opcode(dmem_a_opcode), .dmem_a_param(dmem_a_param),
        .dmem_a_size(dmem_a_size), .dmem_a_source(dmem_a_source), .dmem_a_address(dmem_a_address),
        .dmem_a_mask(dmem_a_mask), .dmem_a_data(dmem_a_data), .dmem_a_corrupt(dmem_a_corrupt),
        .dmem_a_ready(dmem_a_ready), .dmem_d_valid(dmem_d_valid), .dmem_d_opcode(dmem_d_opcode),
        .dmem_d_param(dmem_d_param), .dmem_d_size(dmem_d_size), .dmem_d_source(dmem_d_source),
        .dmem_d_sink(dmem_d_sink), .dmem_d_denied(dmem_d_denied), .dmem_d_data(dmem_d_data),
        .dmem_d_corrupt(dmem_d_corrupt), .dmem_d_ready(dmem_d_ready)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: %0h", tag, observed);
        end
    endtask

    initial begin
        reset_n = 1'b0; interrupts_msip = 1'b0;
        icache_req_valid = 0; icache_req_addr = '0; icache_req_tag = '0; icache_rsp_ready = 0;
        dcache_req_valid = '0; dcache_req_rw = '0; dcache_req_byteen = '0; dcache_req_addr = '0;
        dcache_req_data = '0; dcache_req_tag = '0; dcache_rsp_ready = 0;
        imem_a_ready = 0; imem_d_valid = 0; imem_d_opcode = '0; imem_d_param = '0; imem_d_size = '0;
        imem_d_source = '0; imem_d_sink = '0; imem_d_denied = 0; imem_d_data = '0; imem_d_corrupt = 0;
        dmem_a_ready = '0; dmem_d_valid = '0; dmem_d_opcode = '0; dmem_d_param = '0; dmem_d_size = '0;
        dmem_d_source = '0; dmem_d_sink = '0; dmem_d_denied = '0; dmem_d_data = '0; dmem_d_corrupt = '0;

        // reset state
        repeat (2) @(negedge clock);
        check_value("core_reset_in_reset", core_reset, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check_value("core_reset_after_reset", core_reset, 0);

        // fetch request / response
        icache_req_valid = 1; icache_req_addr = 30'h100; icache_req_tag = 10'd5; imem_a_ready = 1;
        imem_d_valid = 1; imem_d_data = 32'hDEADBEEF; imem_d_source = 10'd5; icache_rsp_ready = 1;
        imem_d_denied = 1; imem_d_corrupt = 1;
        #1;
        check_value("imem_a_valid", imem_a_valid, 1);
        check_value("imem_a_address", imem_a_address, 32'h400);
        check_value("imem_a_opcode", imem_a_opcode, 4);
        check_value("imem_a_source", imem_a_source, 5);
        check_value("imem_a_mask", imem_a_mask, 4'hF);
        check_value("imem_a_size", imem_a_size, 2);
        check_value("icache_req_ready", icache_req_ready, 1);
        check_value("icache_rsp_valid", icache_rsp_valid, 1);
        check_value("icache_rsp_data", icache_rsp_data, 32'hDEADBEEF);
        check_value("icache_rsp_tag", icache_rsp_tag, 5);
        check_value("imem_d_ready", imem_d_ready, 1);
        icache_rsp_ready = 0; #1;
        check_value("imem_d_ready_low", imem_d_ready, 0);

        // stores and loads on the dcache lanes
        dcache_req_valid = 4'b0101; dcache_req_rw = 4'b0100;
        dcache_req_byteen[2] = 4'hF; dcache_req_addr[2] = 30'h3; dcache_req_data[2] = 32'h12345678;
        dcache_req_tag[2] = 10'h2A; dcache_req_byteen[0] = 4'hF; dcache_req_addr[0] = 30'h40;
        dmem_a_ready = 4'b0100;
        #1;
        check_value("lane2_putfull_opcode", dmem_a_opcode[2], 0);
        check_value("lane2_address", dmem_a_address[2], 32'hC);
        check_value("lane2_data", dmem_a_data[2], 32'h12345678);
        check_value("lane2_source", dmem_a_source[2], 10'h2A);
        check_value("lane0_get_opcode", dmem_a_opcode[0], 4);
        check_value("lane0_address", dmem_a_address[0], 32'h100);
        check_value("dmem_a_valid", dmem_a_valid, 4'b0101);
        check_value("dcache_req_ready", dcache_req_ready, 4'b0100);
        dcache_req_byteen[2] = 4'h3; #1;
        check_value("lane2_putpartial_opcode", dmem_a_opcode[2], 1);
        check_value("lane2_mask", dmem_a_mask[2], 4'h3);
        dcache_req_valid = '0;

        // response merge
        dmem_d_valid = 4'b0101; dmem_d_opcode[0] = 3'd1; dmem_d_opcode[2] = 3'd1;
        dmem_d_source[0] = 10'd7; dmem_d_source[2] = 10'd9;
        dmem_d_data[0] = 32'hA0A0A0A0; dmem_d_data[1] = 32'hB1B1B1B1;
        dmem_d_data[2] = 32'hC2C2C2C2; dmem_d_data[3] = 32'hD3D3D3D3;
        dcache_rsp_ready = 0;
        #1;
        check_value("merge_tmask", dcache_rsp_tmask, 4'b0101);
        check_value("merge_tag", dcache_rsp_tag, 9);
        check_value("merge_valid", dcache_rsp_valid, 1);
        check_value("merge_d_ready_low", dmem_d_ready, 4'b0000);
        check_value("merge_data", dcache_rsp_data, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0);
        dcache_rsp_ready = 1; #1;
        check_value("merge_d_ready_high", dmem_d_ready, 4'b1111);
        dmem_d_valid = 4'b0000; #1;
        check_value("idle_tag", dcache_rsp_tag, 0);
        check_value("idle_valid", dcache_rsp_valid, 0);

        // AccessAck-only beat on lane 1
        dmem_d_valid = 4'b0010; dmem_d_opcode[1] = 3'd0; dmem_d_source[1] = 10'd3;
        #1;
        check_value("ack_tmask", dcache_rsp_tmask, 4'b0010);
        check_value("ack_tag", dcache_rsp_tag, 3);
        check_value("ack_d_ready", dmem_d_ready, 4'b1111);
`ifdef VX_TL_ACK_FILTER_EN
        check_value("ack_rsp_valid", dcache_rsp_valid, 0);
`else
        check_value("ack_rsp_valid", dcache_rsp_valid, 1);
`endif
        dmem_d_valid = '0;

        // soft reset: single rise held high -> 16 cycles
        @(negedge clock);
        interrupts_msip = 1;
        high_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (core_reset) high_cnt++;
        end
        check_value("pulse_len_held", high_cnt, 16);
        check_value("pulse_done_low", core_reset, 0);

        // soft reset: second rise reloads at pulse cycle 10 -> 10 + 16 cycles
        interrupts_msip = 0;
        repeat (2) @(negedge clock);
        interrupts_msip = 1;
        high_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (core_reset) high_cnt++;
            if (i == 0) interrupts_msip = 0;
            if (i == 9) interrupts_msip = 1;
        end
        check_value("pulse_len_reload", high_cnt, 26);

        // async reset mid-pulse
        interrupts_msip = 0;
        repeat (2) @(negedge clock);
        interrupts_msip = 1;
        repeat (4) @(negedge clock);
        check_value("pulse_mid_high", core_reset, 1);
        #1 reset_n = 0;
        #1 check_value("core_reset_async", core_reset, 1);
        #1 reset_n = 1;
        #1 check_value("pulse_cleared_async", core_reset, 0);
        interrupts_msip = 0;
        repeat (2) @(negedge clock);
        check_value("pulse_stays_cleared", core_reset, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
